// File: rtl/rr_gnt_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and a per-owner hold limit.
// The owner is rotated out after MAX_HOLD consecutive cycles, but only while another requester waits.
`timescale 1ns/1ps
module rr_gnt_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N),
  localparam int HW      = $clog2(MAX_HOLD + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id,
  output logic [HW-1:0]  hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);
  localparam logic [N-1:0]   ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           vld_q, vld_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic [N-1:0]   cand;
  logic           owner_req;
  logic           win_found;
  logic [IDW-1:0] win_id;
  int             idx;

  // In GRANT the current owner is masked out, so a forced rotation can never re-pick it.
  always_comb begin
    cand      = (state_q == GRANT) ? (req & ~gnt_q) : req;
    owner_req = |(req & gnt_q);
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = ONE_HOT0 << win_id;
          id_d    = win_id;
          hold_d  = '0;
          ptr_d   = (win_id == ID_LAST) ? '0 : win_id + IDW'(1);
        end
      end
      GRANT: begin
        if ((!owner_req || hold_q == HOLD_LAST) && win_found) begin
          gnt_d  = ONE_HOT0 << win_id;
          id_d   = win_id;
          hold_d = '0;
          ptr_d  = (win_id == ID_LAST) ? '0 : win_id + IDW'(1);
        end else if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase

    vld_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_vld  = vld_q;
  assign gnt_id   = id_q;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_rr_gnt_arbiter.sv
// Bench for rr_gnt_arbiter: directed vector table, reset-mid-grant sequence and
// randomized skewed stimulus checked against a rule-level reference model.
`timescale 1ns/1ps
module tb_rr_gnt_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;
  localparam int HW = $clog2(MH + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic          gnt_vld;
  logic [1:0]    gnt_id;
  logic [HW-1:0] hold_cnt;

  int checks = 0;
  int errors = 0;

  rr_gnt_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rstn(rstn), .req(req),
    .gnt(gnt), .gnt_vld(gnt_vld), .gnt_id(gnt_id), .hold_cnt(hold_cnt)
  );

  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // gnt may only move at a rising edge, except for the asynchronous reset
  realtime last_pos = 0.0;
  bit      mon_en = 1'b0;
  int      edge_viol = 0;
  always @(posedge clk) last_pos = $realtime;
  always @(gnt) if (mon_en && rstn && $realtime != last_pos) edge_viol++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_owner = -1;
  int m_ptr = 0;
  int m_hold = 0;

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  function automatic void m_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0;
  endfunction

  function automatic void m_take(input int w);
    m_owner = w; m_hold = 0; m_ptr = (w + 1) % N;
  endfunction

  function automatic void m_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    int w;
    if (m_owner < 0) begin
      w = rr_pick(r, m_ptr);
      if (w >= 0) m_take(w);
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      w = rr_pick(others, m_ptr);
      if (!r[m_owner]) begin
        if (w >= 0) m_take(w);
        else begin m_owner = -1; m_hold = 0; end
      end else if (m_hold == MH - 1) begin
        if (w >= 0) m_take(w);
        else m_hold = 0;
      end else begin
        m_hold++;
      end
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic reset_dut();
    mon_en = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    req  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    m_reset();
  endtask

  typedef struct {
    bit          do_rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic [HW-1:0] hold;
  } vec_t;

  function automatic vec_t mk(input bit rst, input logic [3:0] r, input int owner, input int hold);
    vec_t v;
    v.do_rst = rst;
    v.req    = r;
    v.gnt    = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
    v.id     = (owner < 0) ? 2'd0 : 2'(owner);
    v.hold   = HW'(hold);
    return v;
  endfunction

  vec_t tbl[$];
  logic [N-1:0] req_s;
  int cd[N];
  int wait_c[N];
  int max_wait;
  realtime skews[3] = '{0.001, 2.0, 5.0};

  initial begin
    // single requester: hold wraps every MH cycles, release goes idle
    for (int k = 0; k < 10; k++) tbl.push_back(mk(1'b0, 4'b0100, 2, k % MH));
    tbl.push_back(mk(1'b0, 4'b0000, -1, 0));
    // ptr is now 3: 0 wins, then early-release handovers without idle cycles
    tbl.push_back(mk(1'b0, 4'b0011, 0, 0));
    tbl.push_back(mk(1'b0, 4'b0010, 1, 0));
    tbl.push_back(mk(1'b0, 4'b0011, 1, 1));
    tbl.push_back(mk(1'b0, 4'b0001, 0, 0));
    tbl.push_back(mk(1'b0, 4'b0100, 2, 0));
    tbl.push_back(mk(1'b0, 4'b0000, -1, 0));
    // fairness: ptr=3 with req 1001 -> 3 for MH cycles, then 0
    for (int k = 0; k < MH; k++) tbl.push_back(mk(1'b0, 4'b1001, 3, k));
    tbl.push_back(mk(1'b0, 4'b1001, 0, 0));
    // all requesting from reset: 0,1,2,3,0 each for MH cycles
    for (int k = 0; k < 17; k++) tbl.push_back(mk(k == 0, 4'b1111, (k / MH) % N, k % MH));

    reset_dut();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_vld", 32'(gnt_vld), 0);
    check("rst_id", 32'(gnt_id), 0);
    check("rst_hold", 32'(hold_cnt), 0);

    // reset in the middle of a grant drops gnt without a clock edge
    @(negedge clk) req = 4'b0100;
    @(posedge clk); #1;
    check("pre_rst_gnt", 32'(gnt), 32'h4);
    #4 rstn = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 0);
    check("async_rst_vld", 32'(gnt_vld), 0);
    #2 begin rstn = 1'b1; req = '0; end
    @(posedge clk); #1;
    check("post_rst_idle", 32'(gnt), 0);
    @(negedge clk) req = 4'b1111;
    @(posedge clk); #1;
    check("post_rst_ptr0", 32'(gnt), 32'h1);

    reset_dut();
    foreach (tbl[i]) begin
      if (tbl[i].do_rst) reset_dut();
      @(negedge clk) req = tbl[i].req;
      @(posedge clk); #1;
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("vec%0d_vld", i), 32'(gnt_vld), 32'(|tbl[i].gnt));
      if (tbl[i].gnt != 0) begin
        check($sformatf("vec%0d_id", i), 32'(gnt_id), 32'(tbl[i].id));
        check($sformatf("vec%0d_hold", i), 32'(hold_cnt), 32'(tbl[i].hold));
      end
    end

    // randomized stimulus, req driven a fixed skew after each rising edge
    for (int s = 0; s < 3; s++) begin
      reset_dut();
      for (int i = 0; i < N; i++) begin cd[i] = $urandom_range(0, 15); wait_c[i] = 0; end
      max_wait = 0;
      edge_viol = 0;
      mon_en = 1'b1;
      for (int c = 0; c < 300; c++) begin
        @(posedge clk);
        req_s = req;
        m_step(req_s);
        for (int i = 0; i < N; i++) begin
          if (req_s[i] && m_owner != i) wait_c[i]++;
          else wait_c[i] = 0;
          if (wait_c[i] > max_wait) max_wait = wait_c[i];
        end
        #(skews[s]);
        for (int i = 0; i < N; i++) begin
          if (cd[i] == 0) begin
            req[i] = ~req[i];
            cd[i]  = $urandom_range(0, 15);
          end else begin
            cd[i]--;
          end
        end
        @(negedge clk);
        check("rnd_gnt", 32'(gnt), (m_owner < 0) ? 0 : (32'd1 << m_owner));
        if (m_owner >= 0) begin
          check("rnd_id", 32'(gnt_id), 32'(m_owner));
          check("rnd_hold", 32'(hold_cnt), 32'(m_hold));
        end
        check("onehot0", 32'($onehot0(gnt)), 1);
        check("vld_eq_or", 32'(gnt_vld), 32'(|gnt));
        if (gnt_vld) check("id_matches_gnt", 32'(gnt), 32'd1 << gnt_id);
        check("hold_lt_max", 32'(hold_cnt < MH), 1);
      end
      mon_en = 1'b0;
      check($sformatf("edge_only_s%0d", s), 32'(edge_viol), 0);
      check($sformatf("starve_bound_s%0d", s), 32'(max_wait <= (N - 1) * MH), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
